// File: rtl/alu_add_pgx_stage.sv
// Operand front-end of the SIMD 64-bit adder: per-bit p/g/x, per-lane carry-in, 8-lane carry flags.
// Optional 1-entry skid buffer under ALU_ADD_PGX_SKID_EN (registered in_ready_o).
module alu_add_pgx_stage (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic [1:0]  op_i,
    input  logic [1:0]  op_width_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] p_o,
    output logic [63:0] g_o,
    output logic [63:0] x_o,
    output logic [7:0]  c_o,
    output logic [1:0]  op_width_o,
    input  logic        c_fb_valid_i,
    input  logic [7:0]  c_fb_i
);
    // Width codes match SRAM_PIM_pkg: W8=0, W16=1, W32=2, W64=3.
    localparam logic [1:0] W8  = 2'd0;
    localparam logic [1:0] W16 = 2'd1;
    localparam logic [1:0] W32 = 2'd2;
    localparam logic [1:0] W64 = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;

    typedef struct packed {
        logic [63:0] p;
        logic [63:0] g;
        logic [63:0] x;
        logic [7:0]  c;
        logic [1:0]  w;
    } beat_t;

    logic [7:0]  cflag_q, cflag_d;
    logic [63:0] b_eff;
    logic [7:0]  start_mask, carry_src;
    beat_t       beat_new;
    beat_t       out_q, out_d;
    logic        out_valid_q, out_valid_d;

    // The feedback bypass lets an ADC/SBC accepted alongside the previous carry-out consume it.
    assign cflag_d = c_fb_valid_i ? c_fb_i : cflag_q;
    assign b_eff   = op_i[0] ? ~b_i : b_i;

    always_comb begin
        start_mask = 8'h01;
        case (op_width_i)
            W8:      start_mask = 8'hFF;
            W16:     start_mask = 8'h55;
            W32:     start_mask = 8'h11;
            W64:     start_mask = 8'h01;
            default: start_mask = 8'h01;
        endcase
        carry_src = cflag_d;
        case (op_i)
            OP_ADD:  carry_src = 8'h00;
            OP_SUB:  carry_src = 8'hFF;
            default: carry_src = cflag_d;
        endcase
        beat_new.p = a_i ^ b_eff;
        beat_new.g = a_i & b_eff;
        beat_new.x = a_i ^ b_eff;
        beat_new.c = carry_src & start_mask;
        beat_new.w = op_width_i;
    end

`ifdef ALU_ADD_PGX_SKID_EN
    beat_t skid_q, skid_d;
    logic  skid_full_q, skid_full_d;

    assign in_ready_o = ~skid_full_q;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (skid_full_q) begin
            if (out_ready_i) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end
        end else if (!out_valid_q || out_ready_i) begin
            if (in_valid_i) begin
                out_d       = beat_new;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_valid_i) begin
            skid_d      = beat_new;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else begin
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
        end
    end
`else
    assign in_ready_o = ~out_valid_q | out_ready_i;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (in_valid_i && in_ready_o) begin
            out_d       = beat_new;
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cflag_q     <= 8'h00;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cflag_q     <= cflag_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign p_o         = out_q.p;
    assign g_o         = out_q.g;
    assign x_o         = out_q.x;
    assign c_o         = out_q.c;
    assign op_width_o  = out_q.w;
endmodule
